// File: rtl/coherence_bus_ctrl_pkg.sv
// Shared types for the two-core coherence bus controller.
// RAM handshake states, bus FSM encoding and grant classes.
package coherence_bus_ctrl_pkg;

    typedef enum logic [1:0] {FREE, BUSY, ACCESS, ERROR} ramstate_t;

    typedef logic [3:0] busstate_t;
    localparam busstate_t ARB   = 4'd0;
    localparam busstate_t SNOOP = 4'd1;
    localparam busstate_t SRESP = 4'd2;
    localparam busstate_t CCWB1 = 4'd3;
    localparam busstate_t CCWB2 = 4'd4;
    localparam busstate_t LD1   = 4'd5;
    localparam busstate_t LD2   = 4'd6;
    localparam busstate_t WB1   = 4'd7;
    localparam busstate_t WB2   = 4'd8;
    localparam busstate_t UPG   = 4'd9;
    localparam busstate_t IF    = 4'd10;

    typedef enum logic [1:0] {G_CC, G_WB, G_IF, G_NONE} gclass_t;

    // An ERROR response completes the access just like ACCESS.
    function automatic logic ram_done(input logic [1:0] rs);
        return (rs == ACCESS) || (rs == ERROR);
    endfunction

endpackage

// File: rtl/coherence_bus_ctrl_rr_arbiter2.sv
// Two-requester round-robin arbiter with a high and a low request class.
// The pointer flips only when the owner signals a completed grant.
module rr_arbiter2
    import coherence_bus_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RST,
    input  logic [1:0] req_hi,
    input  logic [1:0] req_lo,
    input  logic       adv,
    output logic       gnt,
    output logic       hi,
    output logic       valid
);

    logic [1:0] req;
    logic       rr;

    assign hi    = |req_hi;
    assign req   = hi ? req_hi : req_lo;
    assign valid = |req;
    assign gnt   = req[rr] ? rr : ~rr;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            rr <= 1'b0;
        end else if (adv) begin
            rr <= ~rr;
        end
    end

endmodule

// File: rtl/coherence_bus_ctrl.sv
// Two-core bus/coherence controller: arbitrates icaches and dcaches onto
// one RAM port and sequences dcache snoops ahead of block loads.
module coherence_bus_ctrl
    import coherence_bus_ctrl_pkg::*;
#(
    parameter int CPUS   = 2,
    parameter int ADDR_W = 32
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [CPUS-1:0]   iREN,
    input  logic [ADDR_W-1:0] iaddr [CPUS],
    output logic [CPUS-1:0]   iwait,
    output logic [ADDR_W-1:0] iload [CPUS],
    input  logic [CPUS-1:0]   dREN,
    input  logic [CPUS-1:0]   dWEN,
    input  logic [ADDR_W-1:0] daddr [CPUS],
    input  logic [ADDR_W-1:0] dstore [CPUS],
    input  logic [CPUS-1:0]   cctrans,
    input  logic [CPUS-1:0]   ccwrite,
    output logic [CPUS-1:0]   dwait,
    output logic [ADDR_W-1:0] dload [CPUS],
    output logic [CPUS-1:0]   ccwait,
    output logic [CPUS-1:0]   ccinv,
    output logic [ADDR_W-1:0] ccsnoopaddr [CPUS],
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  logic [1:0]        ramstate
);

    busstate_t         state, nstate;
    gclass_t           gcls;
    logic              g, p, gnt, hi, valid, adv, acc, inv;
    logic [ADDR_W-1:0] addr;
    logic [CPUS-1:0]   cc_req, wb_req, dreq;

    assign p   = ~g;
    assign acc = ram_done(ramstate);

    // Flushing caches may raise cctrans alongside a pure write; that is a writeback.
    assign wb_req = dWEN & ~dREN;
    assign cc_req = cctrans & ~wb_req;
    assign dreq   = (|cc_req) ? cc_req : wb_req;

    rr_arbiter2 u_arb (
        .CLK    (CLK),
        .RST    (RST),
        .req_hi (dreq),
        .req_lo (iREN),
        .adv    (adv),
        .gnt    (gnt),
        .hi     (hi),
        .valid  (valid)
    );

    always_comb begin
        if (!valid)       gcls = G_NONE;
        else if (!hi)     gcls = G_IF;
        else if (|cc_req) gcls = G_CC;
        else              gcls = G_WB;
    end

    always_comb begin
        nstate = state;
        adv    = 1'b0;
        unique case (state)
            ARB: begin
                unique case (gcls)
                    G_CC:    nstate = SNOOP;
                    G_WB:    nstate = WB1;
                    G_IF:    nstate = IF;
                    default: nstate = ARB;
                endcase
            end
            SNOOP: nstate = SRESP;
            SRESP: begin
                if (ccwrite[p])    nstate = CCWB1;
                else if (dREN[g])  nstate = LD1;
                else               nstate = UPG;
            end
            UPG: begin
                nstate = ARB;
                adv    = 1'b1;
            end
            CCWB1: if (acc) nstate = CCWB2;
            CCWB2: if (acc) nstate = dREN[g] ? LD1 : UPG;
            LD1: begin
                if (!cctrans[g] && !dREN[g]) begin
                    nstate = ARB;
                    adv    = 1'b1;
                end else if (acc) begin
                    nstate = LD2;
                end
            end
            LD2, WB2: begin
                if (acc) begin
                    nstate = ARB;
                    adv    = 1'b1;
                end
            end
            WB1:     if (acc) nstate = WB2;
            IF:      if (acc) nstate = ARB;
            default: nstate = ARB;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state <= ARB;
            g     <= 1'b0;
            addr  <= '0;
            inv   <= 1'b0;
        end else begin
            state <= nstate;
            if (state == ARB && valid) begin
                g    <= gnt;
                addr <= daddr[gnt];
                inv  <= ccwrite[gnt] | dWEN[gnt] | ~dREN[gnt];
            end
        end
    end

    always_comb begin
        iwait    = '1;
        dwait    = '1;
        ccwait   = '0;
        ccinv    = '0;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        for (int i = 0; i < CPUS; i++) begin
            iload[i]       = '0;
            dload[i]       = '0;
            ccsnoopaddr[i] = '0;
        end
        unique case (state)
            SNOOP, SRESP, CCWB1, CCWB2: begin
                ccwait[p]      = 1'b1;
                ccinv[p]       = inv;
                ccsnoopaddr[p] = addr;
                // The peer's dirty words reach RAM before the requester loads.
                if (state == CCWB1 || state == CCWB2) begin
                    ramWEN   = dWEN[p];
                    ramaddr  = daddr[p];
                    ramstore = dstore[p];
                    dwait[p] = ~acc;
                end
            end
            LD1, LD2: begin
                ramREN   = 1'b1;
                ramaddr  = daddr[g];
                dload[g] = ramload;
                dwait[g] = ~acc;
            end
            WB1, WB2: begin
                ramWEN   = 1'b1;
                ramaddr  = daddr[g];
                ramstore = dstore[g];
                dwait[g] = ~acc;
            end
            UPG: dwait[g] = 1'b0;
            IF: begin
                ramREN   = 1'b1;
                ramaddr  = iaddr[g];
                iload[g] = ramload;
                iwait[g] = ~acc;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_coherence_bus_ctrl.sv
// Directed scoreboard bench for coherence_bus_ctrl with a 2-cycle RAM model.
module tb_coherence_bus_ctrl;
    import coherence_bus_ctrl_pkg::*;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [1:0]  iREN, iwait, dREN, dWEN, cctrans, ccwrite;
    logic [1:0]  dwait, ccwait, ccinv;
    logic [31:0] iaddr [2];
    logic [31:0] iload [2];
    logic [31:0] daddr [2];
    logic [31:0] dstore [2];
    logic [31:0] dload [2];
    logic [31:0] ccsnoopaddr [2];
    logic        ramREN, ramWEN;
    logic [31:0] ramaddr, ramstore, ramload;
    logic [1:0]  ramstate;

    always #5 CLK = ~CLK;

    coherence_bus_ctrl dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iwait(iwait), .iload(iload),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .cctrans(cctrans), .ccwrite(ccwrite),
        .dwait(dwait), .dload(dload),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr),
        .ramstore(ramstore), .ramload(ramload), .ramstate(ramstate)
    );

    // RAM model: every access takes LAT cycles; unwritten words read C0DE00<idx>.
    localparam int LAT = 2;
    logic [31:0]  mem [256];
    logic [255:0] wr_ok;
    logic [7:0]   idx;
    int           cnt;

    assign idx      = ramaddr[9:2];
    assign ramstate = (ramREN | ramWEN) ? ((cnt == LAT-1) ? 2'd2 : 2'd1) : 2'd0;
    assign ramload  = wr_ok[idx] ? mem[idx] : {16'hC0DE, 8'h00, idx};

    always @(posedge CLK) begin
        if (RST) begin
            wr_ok <= '0;
            cnt   <= 0;
        end else if (ramREN | ramWEN) begin
            if (cnt == LAT-1) begin
                cnt <= 0;
                if (ramWEN) begin
                    mem[idx]   <= ramstore;
                    wr_ok[idx] <= 1'b1;
                end
            end else begin
                cnt <= cnt + 1;
            end
        end else begin
            cnt <= 0;
        end
    end

    typedef struct packed {
        logic [2:0]  k;
        logic        c;
        logic [31:0] a;
        logic [31:0] d;
    } ev_t;

    localparam logic [2:0] E_SNP = 3'd0;
    localparam logic [2:0] E_RW  = 3'd1;
    localparam logic [2:0] E_RR  = 3'd2;
    localparam logic [2:0] E_DA  = 3'd3;
    localparam logic [2:0] E_IF  = 3'd4;

    ev_t        q[$];
    int         tests = 0;
    int         fails = 0;
    logic [1:0] prev_ccw;

    function automatic ev_t mk(input logic [2:0] kk, input logic cc,
                               input logic [31:0] aa, input logic [31:0] dd);
        ev_t e;
        e.k = kk;
        e.c = cc;
        e.a = aa;
        e.d = dd;
        return e;
    endfunction

    task automatic push(input logic [2:0] kk, input logic cc,
                        input logic [31:0] aa, input logic [31:0] dd);
        q.push_back(mk(kk, cc, aa, dd));
    endtask

    task automatic take(input ev_t o);
        ev_t e;
        tests++;
        if (q.size() == 0) begin
            fails++;
            $display("FAIL unexpected event: got k=%0d c=%0d a=%h d=%h, want none",
                     o.k, o.c, o.a, o.d);
        end else begin
            e = q.pop_front();
            if (e !== o) begin
                fails++;
                $display("FAIL event: got k=%0d c=%0d a=%h d=%h, want k=%0d c=%0d a=%h d=%h",
                         o.k, o.c, o.a, o.d, e.k, e.c, e.a, e.d);
            end
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Monitor: turns DUT outputs into events and checks them against the queue.
    initial begin
        prev_ccw = '0;
        forever begin
            @(negedge CLK);
            if (RST) begin
                prev_ccw = '0;
            end else begin
                for (int c = 0; c < 2; c++)
                    if (ccwait[c] && !prev_ccw[c])
                        take(mk(E_SNP, c[0], ccsnoopaddr[c], {31'b0, ccinv[c]}));
                prev_ccw = ccwait;
                if (ramWEN && ramstate == 2'd2)
                    take(mk(E_RW, 1'b0, ramaddr, ramstore));
                if (ramREN && ramstate == 2'd2)
                    take(mk(E_RR, 1'b0, ramaddr, 32'h0));
                for (int c = 0; c < 2; c++)
                    if (!dwait[c]) take(mk(E_DA, c[0], 32'h0, dload[c]));
                for (int c = 0; c < 2; c++)
                    if (!iwait[c]) take(mk(E_IF, c[0], 32'h0, iload[c]));
            end
        end
    end

    task automatic wait_low(input bit icache, input int c);
        int n = 0;
        do begin
            @(negedge CLK);
            n++;
        end while ((icache ? iwait[c] : dwait[c]) && n < 60);
        if (icache ? iwait[c] : dwait[c]) begin
            tests++;
            fails++;
            $display("FAIL timeout: %s wait[%0d] never dropped", icache ? "i" : "d", c);
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic dc_read(input int c, input logic [31:0] a);
        cctrans[c] = 1'b1;
        dREN[c]    = 1'b1;
        daddr[c]   = a;
        wait_low(1'b0, c);
        daddr[c]   = a + 32'd4;
        wait_low(1'b0, c);
        cctrans[c] = 1'b0;
        dREN[c]    = 1'b0;
    endtask

    task automatic dc_wb(input int c, input logic [31:0] a, input logic [31:0] d0,
                         input logic [31:0] d1, input logic cc);
        ccwrite[c] = 1'b1;
        dWEN[c]    = 1'b1;
        cctrans[c] = cc;
        daddr[c]   = a;
        dstore[c]  = d0;
        wait_low(1'b0, c);
        daddr[c]   = a + 32'd4;
        dstore[c]  = d1;
        wait_low(1'b0, c);
        ccwrite[c] = 1'b0;
        dWEN[c]    = 1'b0;
        cctrans[c] = 1'b0;
    endtask

    task automatic dc_upg(input int c, input logic [31:0] a);
        cctrans[c] = 1'b1;
        dREN[c]    = 1'b0;
        dWEN[c]    = 1'b0;
        daddr[c]   = a;
        wait_low(1'b0, c);
        cctrans[c] = 1'b0;
    endtask

    task automatic fetch(input int c, input logic [31:0] a);
        iREN[c]  = 1'b1;
        iaddr[c] = a;
        wait_low(1'b1, c);
        iREN[c]  = 1'b0;
    endtask

    task automatic drain(input string nm);
        repeat (3) @(posedge CLK);
        #1;
        chk(nm, q.size(), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        iREN = '0; dREN = '0; dWEN = '0; cctrans = '0; ccwrite = '0;
        for (int i = 0; i < 2; i++) begin
            iaddr[i] = '0; daddr[i] = '0; dstore[i] = '0;
        end
        repeat (2) @(posedge CLK);
        #1;
        chk("rst iwait", iwait, 32'h3);
        chk("rst dwait", dwait, 32'h3);
        chk("rst ccwait", ccwait, 32'h0);
        chk("rst ccinv", ccinv, 32'h0);
        chk("rst ramREN", ramREN, 32'h0);
        chk("rst ramWEN", ramWEN, 32'h0);
        chk("rst ramaddr", ramaddr, 32'h0);
        chk("rst ramstore", ramstore, 32'h0);
        chk("rst dload0", dload[0], 32'h0);
        chk("rst iload1", iload[1], 32'h0);
        chk("rst snoopaddr1", ccsnoopaddr[1], 32'h0);
        RST = 1'b0;

        push(E_RR, 0, 32'h100, 0);
        push(E_IF, 0, 0, 32'hC0DE0040);
        fetch(0, 32'h100);
        drain("ifetch core0");

        push(E_SNP, 1, 32'h40, 0);
        push(E_RR, 0, 32'h40, 0);
        push(E_DA, 0, 0, 32'hC0DE0010);
        push(E_RR, 0, 32'h44, 0);
        push(E_DA, 0, 0, 32'hC0DE0011);
        dc_read(0, 32'h40);
        drain("read miss clean peer");

        push(E_SNP, 1, 32'h40, 0);
        push(E_RW, 0, 32'h40, 32'hAA);
        push(E_DA, 1, 0, 0);
        push(E_RW, 0, 32'h44, 32'hBB);
        push(E_DA, 1, 0, 0);
        push(E_RR, 0, 32'h40, 0);
        push(E_DA, 0, 0, 32'hAA);
        push(E_RR, 0, 32'h44, 0);
        push(E_DA, 0, 0, 32'hBB);
        fork
            dc_read(0, 32'h40);
            dc_wb(1, 32'h40, 32'hAA, 32'hBB, 1'b0);
        join
        drain("read miss dirty peer");

        push(E_SNP, 1, 32'hC0, 1);
        push(E_DA, 0, 0, 0);
        push(E_SNP, 0, 32'h48, 0);
        push(E_RR, 0, 32'h48, 0);
        push(E_DA, 1, 0, 32'hC0DE0012);
        push(E_RR, 0, 32'h4C, 0);
        push(E_DA, 1, 0, 32'hC0DE0013);
        fork
            dc_upg(0, 32'hC0);
            dc_read(1, 32'h48);
        join
        drain("dual cctrans rr0");

        push(E_SNP, 1, 32'hD0, 1);
        push(E_DA, 0, 0, 0);
        push(E_SNP, 0, 32'hD4, 1);
        push(E_DA, 1, 0, 0);
        fork
            dc_upg(0, 32'hD0);
            dc_upg(1, 32'hD4);
        join
        drain("dual cctrans rr back to 0");

        push(E_SNP, 0, 32'h80, 1);
        push(E_DA, 1, 0, 0);
        dc_upg(1, 32'h80);
        drain("upgrade core1");

        push(E_RW, 0, 32'h200, 32'h11111111);
        push(E_DA, 1, 0, 0);
        push(E_RW, 0, 32'h204, 32'h22222222);
        push(E_DA, 1, 0, 0);
        push(E_RR, 0, 32'h200, 0);
        push(E_IF, 0, 0, 32'h11111111);
        fork
            dc_wb(1, 32'h200, 32'h11111111, 32'h22222222, 1'b1);
            fetch(0, 32'h200);
        join
        drain("flush wb beats ifetch");

        push(E_SNP, 1, 32'h50, 0);
        push(E_RR, 0, 32'h50, 0);
        push(E_DA, 0, 0, 32'hC0DE0014);
        cctrans[0] = 1'b1;
        dREN[0]    = 1'b1;
        daddr[0]   = 32'h50;
        wait_low(1'b0, 0);
        daddr[0] = 32'h54;
        RST = 1'b1;
        #1;
        chk("mid rst ramREN", ramREN, 32'h0);
        chk("mid rst dwait", dwait, 32'h3);
        chk("mid rst ccwait", ccwait, 32'h0);
        chk("mid rst ramaddr", ramaddr, 32'h0);
        @(posedge CLK);
        #1;
        RST        = 1'b0;
        cctrans[0] = 1'b0;
        dREN[0]    = 1'b0;
        drain("reset during LD2");

        push(E_RR, 0, 32'h100, 0);
        push(E_IF, 1, 0, 32'hC0DE0040);
        fetch(1, 32'h100);
        drain("ifetch core1 after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
